maxnet_ctrl: RTL and testbench
==============================

# maxnet_ctrl

- Iteration controller for the Maxnet network.
- Sits directly upstream of the six-entry float register bank and drives that bank's `load` and its input-source select.
- Inspects the bank's registered outputs `q0`–`q5` after every load and decides whether to run another inhibition iteration or stop.
- On stop, reports the winning neuron index.

## Interface

**Parameters**
- `NLAT`, default 4: latency in cycles of the external inhibition datapath, from valid `q*` to valid next-state `d*`; legal range 1–15.
- `N_ITER_MAX`, default 63: maximum number of feedback loads; legal range 1–63.

**Ports**
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk`, in, 1: rising-edge clock.
  - `rst_n`, in, 1: synchronous active-low reset.
- `start`, in, 1: begin a run; sampled only in IDLE.
- `q0`–`q5`, in, 32 each: IEEE-754 single-precision values from the register bank.
- `load`, out, 1: drives the register bank `load`.
- `init_sel`, out, 1: 1 routes the external input vector to the bank `d*`; 0 routes the datapath results.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of a run.
- `winner`, out, 3: index 0–5 of the surviving neuron.
- `winner_valid`, out, 1: exactly one neuron survived.
- `iter_cnt`, out, 6: number of feedback loads performed in the current or last run.
- `timeout`, out, 1: run ended on the iteration limit.

## Operation

**States:** IDLE, INIT, CHECK, COMPUTE, UPDATE, DONE.

**Transitions and actions**
- IDLE:
  - `start`=1 → INIT.
  - Clear `iter_cnt`, `timeout`, `winner`, `winner_valid` on this transition.
- INIT:
  - `load`=1, `init_sel`=1 for one cycle → CHECK.
- CHECK:
  - Evaluate `q*` combinationally.
  - Active count ≤1 → DONE.
  - Else, limit reached (macro enabled) → DONE with `timeout`=1.
  - Else → COMPUTE.
- COMPUTE:
  - Hold for `NLAT` cycles using an internal 4-bit counter → UPDATE.
- UPDATE:
  - `load`=1, `init_sel`=0 for one cycle.
  - `iter_cnt` += 1 → CHECK.
- DONE:
  - `done`=1 for one cycle → IDLE.

**Activity and winner rules**
- Value i is active iff `q_i[31]`=0 and `q_i[30:0]`≠0.
- Negatives, +0 and −0 are inactive.
- `winner` is the lowest-index active value, registered on leaving CHECK for DONE.
- If none is active: `winner`=0, `winner_valid`=0.
- `winner`, `winner_valid`, `timeout` and `iter_cnt` hold their values until the next `start` is accepted.

**Other rules**
- `start` is ignored while `busy`=1.
- `init_sel` stays 1 outside UPDATE. It is don't-care when `load`=0 but is driven deterministically.
- `iter_cnt` saturates at 63.

## Timing

- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0, except `init_sel`=1.
  - This applies mid-run as well: any `load` in progress is dropped from the next cycle onward.
- Startup sequence:
  - `start` sampled at edge E0.
  - INIT occupies cycle 1; the bank captures at E1.
  - CHECK occupies cycle 2, reading the new `q*`.
- Iteration period is `NLAT`+2 cycles (CHECK + COMPUTE×`NLAT` + UPDATE).
- `done` is asserted the cycle after the terminating CHECK.
- Best case: `start` to `done` is 3 cycles.
- Run-length bound: for k feedback loads, `done` occurs in cycle 3 + k·(`NLAT`+2).
- `busy` falls in the same cycle `done` falls, i.e. the cycle after the pulse.

## Configuration

- Macro `MAXNET_TIMEOUT_EN` defined:
  - CHECK enforces `iter_cnt` == `N_ITER_MAX` as a termination condition.
  - `timeout` reports it.
- Macro undefined:
  - There is no limit check; the run ends only on convergence.
  - `timeout` is tied to 0.
  - Inputs with tied maxima may never terminate; this is the accepted behaviour.

## Test plan

- Single survivor: `q`={0,0,0x3F800000,0,0,0}, `start` → `load`/`init_sel`=1 in cycle 1, `done` in cycle 3, `winner`=2, `winner_valid`=1, `iter_cnt`=0.
- All inactive: `q`={0x00000000, 0x80000000, 0xBF800000, 0, 0, 0xC0000000} → `done` in cycle 3, `winner`=0, `winner_valid`=0, `timeout`=0.
- Convergence: bench model zeroes one more value per UPDATE, starting with 4 active; `NLAT`=4 → 3 UPDATE pulses, `done` in cycle 21, `iter_cnt`=3, and `winner` = the last active index.
- Timeout (macro on, `N_ITER_MAX`=3): all six `q`=0x40000000, held constant → `done` after 3 UPDATEs, `timeout`=1, `iter_cnt`=3, `winner`=0, `winner_valid`=0.
- Reset mid-run: `rst_n`=0 during the 2nd COMPUTE cycle → next cycle `busy`=0, `load`=0, `iter_cnt`=0; `start` pulses while busy are ignored and no spurious INIT occurs.
- Back-to-back: `start` held high through `done` → a new run begins from IDLE the cycle after DONE, and the results clear on acceptance.

Source files
------------

// File: rtl/maxnet_ctrl.sv
// -----------------------------------------------------------------------------
// maxnet_ctrl
//
// Iteration controller for a six-neuron Maxnet. It sits in front of a six-entry
// float register bank and drives that bank's load strobe and input-source
// select. After every load it looks at the bank outputs. It then either starts
// another inhibition iteration through the external datapath, or stops and
// reports the surviving neuron.
//
// Parameters
//   NLAT        latency (cycles) of the external inhibition datapath, 1..15
//   N_ITER_MAX  limit on feedback loads, 1..63 (used only with the macro below)
//
// Optional feature
//   MAXNET_TIMEOUT_EN  when defined, a run also ends once iter_cnt reaches
//                      N_ITER_MAX, and timeout flags it. When undefined, a run
//                      ends only on convergence and timeout is constant 0.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         begin a run (sampled only in IDLE)
//   q0..q5        IEEE-754 single values from the register bank
//   load          bank load strobe
//   init_sel      1: bank takes the external vector, 0: bank takes datapath results
//   busy          high in every state except IDLE
//   done          one-cycle pulse at the end of a run
//   winner        lowest-index active neuron (0 if none)
//   winner_valid  exactly one neuron is active
//   iter_cnt      feedback loads in the current/last run (saturates at 63)
//   timeout       run ended on the iteration limit
//   dbg_state     current FSM state encoding, for observation only
//
// Handshake: start is a level sampled on each rising edge while IDLE. Once it
// is accepted, the controller ignores start until it is back in IDLE. That is
// one cycle after the done pulse.
// -----------------------------------------------------------------------------
module maxnet_ctrl #(
  parameter int NLAT       = 4,
  parameter int N_ITER_MAX = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] q0,
  input  logic [31:0] q1,
  input  logic [31:0] q2,
  input  logic [31:0] q3,
  input  logic [31:0] q4,
  input  logic [31:0] q5,
  output logic        load,
  output logic        init_sel,
  output logic        busy,
  output logic        done,
  output logic [2:0]  winner,
  output logic        winner_valid,
  output logic [5:0]  iter_cnt,
  output logic        timeout,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_CHECK   = 3'd2,
    S_COMPUTE = 3'd3,
    S_UPDATE  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      state_q;
  logic        load_q;
  logic        init_sel_q;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  winner_q;
  logic        winner_valid_q;
  logic [5:0]  iter_cnt_q;
  logic        timeout_q;
  logic [3:0]  lat_cnt_q;

  // A neuron is active only if strictly positive. Negatives and both zeros
  // are inactive.
  logic [5:0] act;
  assign act[0] = ~q0[31] & (|q0[30:0]);
  assign act[1] = ~q1[31] & (|q1[30:0]);
  assign act[2] = ~q2[31] & (|q2[30:0]);
  assign act[3] = ~q3[31] & (|q3[30:0]);
  assign act[4] = ~q4[31] & (|q4[30:0]);
  assign act[5] = ~q5[31] & (|q5[30:0]);

  logic [2:0] act_cnt_d;
  logic [2:0] first_idx_d;

  always_comb begin
    act_cnt_d   = 3'd0;
    first_idx_d = 3'd0;
    // Scan from the top down so the lowest active index wins.
    for (int i = 5; i >= 0; i--) begin
      if (act[i]) first_idx_d = 3'(i);
    end
    for (int i = 0; i < 6; i++) begin
      act_cnt_d = act_cnt_d + {2'b00, act[i]};
    end
  end

  logic converged_d;
  logic limit_hit_d;
  assign converged_d = (act_cnt_d <= 3'd1);

`ifdef MAXNET_TIMEOUT_EN
  assign limit_hit_d = (iter_cnt_q == 6'(N_ITER_MAX));
`else
  // No iteration limit. Tied maxima may keep the run going indefinitely.
  assign limit_hit_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      load_q         <= 1'b0;
      init_sel_q     <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      winner_q       <= 3'd0;
      winner_valid_q <= 1'b0;
      iter_cnt_q     <= 6'd0;
      timeout_q      <= 1'b0;
      lat_cnt_q      <= 4'd0;
    end else begin
      // Strobes default low. init_sel drops only while an UPDATE load is
      // presented.
      load_q     <= 1'b0;
      init_sel_q <= 1'b1;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q        <= S_INIT;
            load_q         <= 1'b1;
            busy_q         <= 1'b1;
            iter_cnt_q     <= 6'd0;
            timeout_q      <= 1'b0;
            winner_q       <= 3'd0;
            winner_valid_q <= 1'b0;
          end
        end
        S_INIT: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (converged_d || limit_hit_d) begin
            state_q        <= S_DONE;
            done_q         <= 1'b1;
            winner_q       <= first_idx_d;
            winner_valid_q <= (act_cnt_d == 3'd1);
            // Convergence takes priority. Timeout is reported only when
            // the run stops with more than one neuron still active.
            timeout_q      <= ~converged_d;
          end else begin
            state_q   <= S_COMPUTE;
            lat_cnt_q <= 4'd0;
          end
        end
        S_COMPUTE: begin
          if (lat_cnt_q == 4'(NLAT - 1)) begin
            state_q    <= S_UPDATE;
            load_q     <= 1'b1;
            init_sel_q <= 1'b0;
          end else begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
          end
        end
        S_UPDATE: begin
          state_q <= S_CHECK;
          if (iter_cnt_q != 6'd63) iter_cnt_q <= iter_cnt_q + 6'd1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load         = load_q;
  assign init_sel     = init_sel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
  assign iter_cnt     = iter_cnt_q;
  assign timeout      = timeout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for maxnet_ctrl. It contains a behavioural model of the six-entry
// register bank and the inhibition datapath. feed_mode selects how the
// datapath result is produced from the current bank contents:
//   0: values held unchanged
//   1: the lowest-index active value is zeroed
// Cycle numbering: the start edge is E0, and cycle k is the cycle that follows
// edge E(k-1).
// -----------------------------------------------------------------------------
module tb_maxnet_ctrl;

  localparam int NLAT       = 4;
  localparam int N_ITER_MAX = 3;
  localparam int W          = 19; // {done_cyc[7:0], winner[2:0], valid, iter[5:0], timeout}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bank [6];
  logic [31:0] ext_vec [6];
  logic [31:0] fb_vec [6];
  logic        fb_found;
  int          feed_mode = 0;

  logic        load, init_sel, busy, done, winner_valid, timeout;
  logic [2:0]  winner;
  logic [5:0]  iter_cnt;
  logic [2:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUT ----------------
  maxnet_ctrl #(.NLAT(NLAT), .N_ITER_MAX(N_ITER_MAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .q0           (bank[0]),
    .q1           (bank[1]),
    .q2           (bank[2]),
    .q3           (bank[3]),
    .q4           (bank[4]),
    .q5           (bank[5]),
    .load         (load),
    .init_sel     (init_sel),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .winner_valid (winner_valid),
    .iter_cnt     (iter_cnt),
    .timeout      (timeout),
    .dbg_state    (dbg_state)
  );

  // ---------------- bank + datapath model ----------------
  function automatic logic is_active(input logic [31:0] v);
    return (v[31] == 1'b0) && (v[30:0] != 31'd0);
  endfunction

  always_comb begin
    fb_found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fb_vec[i] = bank[i];
      if (feed_mode == 1 && !fb_found && is_active(bank[i])) begin
        fb_vec[i] = 32'h0;
        fb_found  = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) bank[i] <= 32'h0;
    end else if (load) begin
      for (int i = 0; i < 6; i++) bank[i] <= init_sel ? ext_vec[i] : fb_vec[i];
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] make_exp(input int dc, input int w, input logic v,
                                            input int it, input logic to);
    logic [7:0] dc8;
    logic [2:0] w3;
    logic [5:0] it6;
    dc8 = 8'(dc);
    w3  = 3'(w);
    it6 = 6'(it);
    return {dc8, w3, v, it6, to};
  endfunction

  task automatic set_ext(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [31:0] e, input logic [31:0] f);
    ext_vec[0] = a; ext_vec[1] = b; ext_vec[2] = c;
    ext_vec[3] = d; ext_vec[4] = e; ext_vec[5] = f;
  endtask

  // Push the expected result, then present start for the E0 edge. Returns in
  // cycle 1.
  task automatic launch(input logic [W-1:0] exp);
    exp_q.push_back(exp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called in cycle 1. Advances until done is seen or the budget expires.
  // Counts INIT and UPDATE loads on the way. poke_cyc > 1 pulses start for one
  // cycle while the run is busy.
  task automatic run_to_done(input int poke_cyc, output int cyc, output int n_upd,
                             output int n_init);
    cyc = 1; n_upd = 0; n_init = 0;
    while (1) begin
      if (load && init_sel)  n_init++;
      if (load && !init_sel) n_upd++;
      if (done || cyc >= 200) break;
      @(posedge clk); #1;
      cyc++;
      if (poke_cyc > 1 && cyc == poke_cyc) start = 1'b1;
      else if (poke_cyc > 1 && cyc == poke_cyc + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset load: got %b want 0", load); end
    checks++; if (init_sel !== 1'b1) begin errors++; $display("FAIL reset init_sel: got %b want 1", init_sel); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++; if (winner !== 3'd0 || winner_valid !== 1'b0) begin errors++; $display("FAIL reset winner: got %0d/%b want 0/0", winner, winner_valid); end
    checks++; if (iter_cnt !== 6'd0 || timeout !== 1'b0) begin errors++; $display("FAIL reset iter/timeout: got %0d/%b want 0/0", iter_cnt, timeout); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int cyc, nu, ni;
    logic [W-1:0] e;
    feed_mode = 0;
    set_ext(32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0, 32'h0);
    launch(make_exp(3, 2, 1'b1, 0, 1'b0));
    checks++; if (load !== 1'b1 || init_sel !== 1'b1) begin errors++; $display("FAIL single init load: got %b/%b want 1/1", load, init_sel); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single busy c1: got %b want 1", busy); end
    run_to_done(0, cyc, nu, ni);
    e = exp_q.pop_front();
    checks++; if (cyc !== int'(e[18:11])) begin errors++; $display("FAIL single done cycle: got %0d want %0d", cyc, e[18:11]); end
    checks++; if (winner !== e[10:8] || winner_valid !== e[7]) begin errors++; $display("FAIL single winner: got %0d/%b want %0d/%b", winner, winner_valid, e[10:8], e[7]); end
    checks++; if (iter_cnt !== e[6:1] || timeout !== e[0]) begin errors++; $display("FAIL single iter/timeout: got %0d/%b want %0d/%b", iter_cnt, timeout, e[6:1], e[0]); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL single after done busy/done: got %b/%b want 0/0", busy, done); end
    checks++; if (winner !== 3'd2 || winner_valid !== 1'b1) begin errors++; $display("FAIL single hold winner: got %0d/%b want 2/1", winner, winner_valid); end
  endtask

  task automatic test_all_inactive();
    int cyc, nu, ni;
    logic [W-1:0] e;
    feed_mode = 0;
    set_ext(32'h00000000, 32'h80000000, 32'hBF800000, 32'h0, 32'h0, 32'hC0000000);
    launch(make_exp(3, 0, 1'b0, 0, 1'b0));
    run_to_done(0, cyc, nu, ni);
    e = exp_q.pop_front();
    checks++; if (cyc !== int'(e[18:11])) begin errors++; $display("FAIL inactive done cycle: got %0d want %0d", cyc, e[18:11]); end
    checks++; if (winner !== e[10:8] || winner_valid !== e[7]) begin errors++; $display("FAIL inactive winner: got %0d/%b want %0d/%b", winner, winner_valid, e[10:8], e[7]); end
    checks++; if (iter_cnt !== e[6:1] || timeout !== e[0]) begin errors++; $display("FAIL inactive iter/timeout: got %0d/%b want %0d/%b", iter_cnt, timeout, e[6:1], e[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_converge();
    int cyc, nu, ni, poke;
    logic [W-1:0] e;
    feed_mode = 1;
    // Active at 1, 2, 4, 5. Each UPDATE zeroes the lowest active value, so 5
    // survives after three loads. done falls in cycle 3 + 3*(NLAT+2).
    set_ext(32'h0, 32'h3F800000, 32'h40000000, 32'hBF000000, 32'h3F000000, 32'h40400000);
    poke = $urandom_range(3, 6);
    launch(make_exp(3 + 3 * (NLAT + 2), 5, 1'b1, 3, 1'b0));
    run_to_done(poke, cyc, nu, ni);
    e = exp_q.pop_front();
    checks++; if (cyc !== int'(e[18:11])) begin errors++; $display("FAIL converge done cycle: got %0d want %0d", cyc, e[18:11]); end
    checks++; if (winner !== e[10:8] || winner_valid !== e[7]) begin errors++; $display("FAIL converge winner: got %0d/%b want %0d/%b", winner, winner_valid, e[10:8], e[7]); end
    checks++; if (iter_cnt !== e[6:1] || timeout !== e[0]) begin errors++; $display("FAIL converge iter/timeout: got %0d/%b want %0d/%b", iter_cnt, timeout, e[6:1], e[0]); end
    checks++; if (nu !== 3) begin errors++; $display("FAIL converge update pulses: got %0d want 3", nu); end
    checks++; if (ni !== 1) begin errors++; $display("FAIL converge init loads (start while busy): got %0d want 1", ni); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int cyc, nu, ni;
    feed_mode = 0;
    set_ext(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
`ifdef MAXNET_TIMEOUT_EN
    begin
      logic [W-1:0] e;
      launch(make_exp(3 + N_ITER_MAX * (NLAT + 2), 0, 1'b0, N_ITER_MAX, 1'b1));
      run_to_done(0, cyc, nu, ni);
      e = exp_q.pop_front();
      checks++; if (cyc !== int'(e[18:11])) begin errors++; $display("FAIL timeout done cycle: got %0d want %0d", cyc, e[18:11]); end
      checks++; if (winner !== e[10:8] || winner_valid !== e[7]) begin errors++; $display("FAIL timeout winner: got %0d/%b want %0d/%b", winner, winner_valid, e[10:8], e[7]); end
      checks++; if (iter_cnt !== e[6:1] || timeout !== e[0]) begin errors++; $display("FAIL timeout iter/timeout: got %0d/%b want %0d/%b", iter_cnt, timeout, e[6:1], e[0]); end
      checks++; if (nu !== N_ITER_MAX) begin errors++; $display("FAIL timeout update pulses: got %0d want %0d", nu, N_ITER_MAX); end
      @(posedge clk); #1;
    end
`else
    // Without the limit, tied maxima never converge. After the iteration limit
    // would have passed, the run must still be going, with timeout low.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; nu = 0; ni = 0;
    repeat (40) begin
      if (done) ni++;
      if (load && !init_sel) nu++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (busy !== 1'b1 || ni !== 0) begin errors++; $display("FAIL nolimit still running: busy %b dones %0d want 1/0", busy, ni); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL nolimit timeout: got %b want 0", timeout); end
    checks++; if (nu !== 6 || iter_cnt !== 6'd6) begin errors++; $display("FAIL nolimit updates: got %0d/%0d want 6/6", nu, iter_cnt); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid();
    int c, nload;
    feed_mode = 1;
    set_ext(32'h0, 32'h3F800000, 32'h40000000, 32'h0, 32'h3F000000, 32'h40400000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    // Advance to cycle 10, the 2nd COMPUTE cycle of the second iteration.
    // Pulse start in cycle 3 on the way; it must be ignored.
    while (c < 10) begin
      @(posedge clk); #1;
      c++;
      start = (c == 3);
    end
    start = 1'b0;
    checks++; if (dbg_state !== 3'd3 || iter_cnt !== 6'd1) begin errors++; $display("FAIL midrst pre state/iter: got %0d/%0d want 3/1", dbg_state, iter_cnt); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || load !== 1'b0) begin errors++; $display("FAIL midrst busy/load: got %b/%b want 0/0", busy, load); end
    checks++; if (iter_cnt !== 6'd0 || init_sel !== 1'b1) begin errors++; $display("FAIL midrst iter/init_sel: got %0d/%b want 0/1", iter_cnt, init_sel); end
    rst_n = 1'b1;
    nload = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (load || busy) nload++;
    end
    checks++; if (nload !== 0) begin errors++; $display("FAIL midrst spurious activity: got %0d cycles want 0", nload); end
  endtask

  task automatic test_back_to_back();
    int cyc, nu, ni;
    logic [W-1:0] e;
    feed_mode = 0;
    set_ext(32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0, 32'h0);
    exp_q.push_back(make_exp(3, 2, 1'b1, 0, 1'b0));
    start = 1'b1;
    @(posedge clk); #1;
    run_to_done(0, cyc, nu, ni);
    start = 1'b1; // keep held through the end of the run
    e = exp_q.pop_front();
    checks++; if (cyc !== int'(e[18:11]) || winner !== e[10:8]) begin errors++; $display("FAIL b2b run1: cycle %0d winner %0d want %0d/%0d", cyc, winner, e[18:11], e[10:8]); end
    @(posedge clk); #1; // cycle 4: back in IDLE, start still high
    checks++; if (busy !== 1'b0 || load !== 1'b0) begin errors++; $display("FAIL b2b idle gap busy/load: got %b/%b want 0/0", busy, load); end
    set_ext(32'h0, 32'h0, 32'h0, 32'h0, 32'h3F800000, 32'h0);
    exp_q.push_back(make_exp(3, 4, 1'b1, 0, 1'b0));
    @(posedge clk); #1; // cycle 1 of run 2
    start = 1'b0;
    checks++; if (load !== 1'b1 || init_sel !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b run2 init: got load %b sel %b busy %b want 1/1/1", load, init_sel, busy); end
    checks++; if (winner !== 3'd0 || winner_valid !== 1'b0) begin errors++; $display("FAIL b2b clear on accept: got %0d/%b want 0/0", winner, winner_valid); end
    run_to_done(0, cyc, nu, ni);
    e = exp_q.pop_front();
    checks++; if (cyc !== int'(e[18:11])) begin errors++; $display("FAIL b2b run2 done cycle: got %0d want %0d", cyc, e[18:11]); end
    checks++; if (winner !== e[10:8] || winner_valid !== e[7]) begin errors++; $display("FAIL b2b run2 winner: got %0d/%b want %0d/%b", winner, winner_valid, e[10:8], e[7]); end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    set_ext(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_single();
    test_all_inactive();
    test_converge();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
